// File: rtl/xadac_vrf_sbd.sv
// Vector register scoreboard: counts outstanding writes per vector register
// and holds back issue requests that would read a register with a write still
// in flight, or that would push its destination past the pending limit.
module xadac_vrf_sbd #(
  parameter  int NoVregs    = 32,
  parameter  int NoVs       = 3,
  parameter  int MaxPending = 3,
  localparam int AW         = $clog2(NoVregs),
  localparam int CW         = $clog2(MaxPending + 1)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               iss_valid,
  output logic               iss_ready,
  input  logic [NoVs*AW-1:0] iss_vs_addr,
  input  logic [NoVs-1:0]    iss_vs_used,
  input  logic [AW-1:0]      iss_vd_addr,
  input  logic               iss_vd_write,
  output logic               exe_valid,
  input  logic               exe_ready,
  input  logic               wb_valid,
  input  logic               wb_ready,
  input  logic [AW-1:0]      wb_vd_addr,
  input  logic               wb_vd_write,
  input  logic               flush,
  output logic [NoVregs-1:0] pending,
  output logic               busy,
  output logic               err,
  output logic [31:0]        stall_cnt
);

  logic [CW-1:0]      cnt_q [NoVregs];
  logic [CW-1:0]      cnt_d [NoVregs];
  logic               err_q, err_d;
  logic [31:0]        stall_cnt_q, stall_cnt_d;

  logic               raw_hazard;
  logic               ovf_hazard;
  logic               hazard;
  logic               iss_fire;
  logic               wb_fire;
  logic [NoVregs-1:0] inc_vec;
  logic [NoVregs-1:0] dec_vec;
  logic [NoVregs-1:0] uflow_vec;

  // RAW check over the used sources, against registered counters only (no writeback bypass)
  always_comb begin
    raw_hazard = 1'b0;
    for (int j = 0; j < NoVs; j++) begin
      if (iss_vs_used[j] && (cnt_q[iss_vs_addr[j*AW +: AW]] != '0)) begin
        raw_hazard = 1'b1;
      end
    end
  end

  assign ovf_hazard = iss_vd_write && (cnt_q[iss_vd_addr] == CW'(MaxPending));
  assign hazard     = raw_hazard | ovf_hazard;

  // While in reset nothing may be handed downstream or accepted upstream.
  assign exe_valid  = rstn & iss_valid & ~hazard;
  assign iss_ready  = rstn & exe_ready & ~hazard;

  assign iss_fire   = iss_valid & iss_ready;
  assign wb_fire    = wb_valid & wb_ready & wb_vd_write;

  // Per-register increment/decrement strobes and the pending view
  for (genvar gi = 0; gi < NoVregs; gi++) begin : g_reg
    assign inc_vec[gi] = iss_fire & iss_vd_write & (iss_vd_addr == AW'(gi));
    assign dec_vec[gi] = wb_fire & (wb_vd_addr == AW'(gi));
    assign pending[gi] = (cnt_q[gi] != '0);
  end

  // Counter next state: flush wins, same-register issue+writeback nets to zero,
  // a decrement of an empty counter is flagged instead of wrapping.
  always_comb begin
    for (int i = 0; i < NoVregs; i++) begin
      cnt_d[i]     = cnt_q[i];
      uflow_vec[i] = 1'b0;
      if (flush) begin
        cnt_d[i] = '0;
      end else if (inc_vec[i] && !dec_vec[i]) begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end else if (dec_vec[i] && !inc_vec[i]) begin
        if (cnt_q[i] == '0) begin
          uflow_vec[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] - CW'(1);
        end
      end
    end
  end

  // Sticky error and saturating stall counter next state
  always_comb begin
    err_d       = err_q | (|uflow_vec);
    stall_cnt_d = stall_cnt_q;
    if (iss_valid && hazard && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NoVregs; i++) begin
        cnt_q[i] <= '0;
      end
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NoVregs; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign busy      = |pending;
  assign err       = err_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/xadac_vrf_sbd.md
# xadac_vrf_sbd

Vector register scoreboard between the decode/issue stage and the vector register file read port. It tracks outstanding vector-register writes per architectural register and gates execute requests with RAW hazards or destination-counter overflow. Writes retire on the execute-response handshake. Handshakes that pass the gate are combinational, with zero added latency.

## Interface
Parameters:
- `NoVregs`, 32, number of architectural vector registers (address width `AW = $clog2(NoVregs)`).
- `NoVs`, 3, number of vector source operands per instruction.
- `MaxPending`, 3, maximum outstanding writes per register (counter width `CW = $clog2(MaxPending+1)`).

Ports:
- `clk`, in, 1, single clock; all state on rising edge.
- `rstn`, in, 1, asynchronous active-low reset.
- `iss_valid`, in, 1, upstream execute request valid.
- `iss_ready`, out, 1, upstream ready.
- `iss_vs_addr`, in, NoVs*AW, source register addresses.
- `iss_vs_used`, in, NoVs, per-source "operand read" flag.
- `iss_vd_addr`, in, AW, destination register.
- `iss_vd_write`, in, 1, instruction writes `iss_vd_addr`.
- `exe_valid`, out, 1, request valid toward the VRF/execute unit.
- `exe_ready`, in, 1, execute unit ready.
- `wb_valid`, in, 1, execute response valid.
- `wb_ready`, in, 1, execute response accepted downstream.
- `wb_vd_addr`, in, AW, response destination id.
- `wb_vd_write`, in, 1, response writes the VRF.
- `flush`, in, 1, synchronous clear of all pending state.
- `pending`, out, NoVregs, bit i = counter[i] != 0.
- `busy`, out, 1, OR of `pending`.
- `err`, out, 1, sticky underflow flag.
- `stall_cnt`, out, 32, saturating count of hazard-stall cycles.

## Operation
- State:
  - `cnt[NoVregs]` of CW bits each.
  - `err`.
  - `stall_cnt`.
  - All reset to 0; all outputs 0 in reset.
- `hazard` is computed only from registered counters; there is no bypass from the writeback of the same cycle. It is asserted when either condition holds:
  - RAW: any source j with `iss_vs_used[j]` and `cnt[iss_vs_addr[j]] != 0`.
  - Overflow: `iss_vd_write` and `cnt[iss_vd_addr] == MaxPending`.
- Gating:
  - `exe_valid = iss_valid & ~hazard`.
  - `iss_ready = exe_ready & ~hazard`.
  - `exe_valid` never depends on `exe_ready`.
- Issue fire (`iss_valid & iss_ready`) with `iss_vd_write` increments `cnt[iss_vd_addr]`.
- WAW is allowed up to `MaxPending`. Sources unused by the instruction are ignored.
- Writeback fire (`wb_valid & wb_ready & wb_vd_write`) decrements `cnt[wb_vd_addr]`.
- Underflow: a writeback to a register with `cnt == 0` sets `err` (sticky until reset) and leaves the counter at 0.
- Simultaneous issue and writeback:
  - Same register: counter unchanged (net zero).
  - Different registers: both updates apply.
- `stall_cnt` increments each cycle with `iss_valid & hazard`; it saturates at 2^32-1.
- `flush` has priority over issue and writeback in the same cycle.
  - Clears all counters.
  - Does not clear `err` or `stall_cnt`.
  - Gating in the flush cycle still uses the pre-flush counters.

## Timing
- Issue path `iss_*` -> `exe_valid`/`iss_ready` is combinational, with 0 cycles latency.
- A hazard clears in the cycle after the writeback fire. VRF writes are synchronous, so an issue in the writeback cycle would read stale data.
- `pending`/`busy` reflect registered counters and update one cycle after the fire.
- Reset asserted mid-operation:
  - All counters, `err` and `stall_cnt` clear immediately (asynchronously).
  - `exe_valid` and `iss_ready` are forced 0 while `rstn` is low.

## Test plan
- Back-to-back independent ops:
  - Stimulus: op A writes v1; op B reads v2,v3 and writes v4; `exe_ready=1`, no writeback.
  - Response: both issue in consecutive cycles; `pending` = 0x12; `stall_cnt` = 0.
- RAW stall:
  - Stimulus: op writing v5 issues; next op reads v5; writeback of v5 fires at cycle 4.
  - Response: `exe_valid` = 0 in cycles 1-4; issue in cycle 5; `stall_cnt` = 4; `pending[5]` = 0 from cycle 5.
- WAW saturation:
  - Stimulus: four consecutive ops writing v7, `MaxPending`=3, no writeback.
  - Response: first three issue; fourth stalls until one v7 writeback, then issues the next cycle; `cnt[7]` returns to 3.
- Simultaneous issue and writeback on v9:
  - Stimulus: `cnt[9]`=1; issue writing v9 and writeback of v9 in the same cycle.
  - Response: `cnt[9]` stays 1; `pending[9]` stays 1.
- Underflow and flush:
  - Stimulus: writeback of v3 with `cnt[3]`=0.
  - Response: `err`=1 next cycle; `cnt[3]`=0.
  - Stimulus: `flush` with v1,v2 pending.
  - Response: `pending`=0 and `busy`=0 next cycle; `err` still 1.
- Async reset mid-stall:
  - Stimulus: `rstn` dropped mid-stall, between clock edges.
  - Response: `pending`, `err`, `stall_cnt` and `exe_valid` read 0 before the next edge.
